// File: rtl/pc_pkg.sv
// Shared definitions for the MIMA program-counter slice.
//   XLEN        address/data width in bits
//   RESET_VEC   value the PC takes while reset is asserted
//   ILEN_BYTES  size of one instruction; used as the sequential PC step
//   pc_sel_e    next-PC source selection used by the control path
//   pc_sel()    maps the jump controls to a pc_sel_e
package pc_pkg;

   localparam int unsigned      XLEN       = 32;
   localparam logic [XLEN-1:0]  RESET_VEC  = 32'h0000_0000;
   localparam int unsigned      ILEN_BYTES = 4;

   typedef enum logic [1:0] {
      PC_SEQ = 2'd0,
      PC_ABS = 2'd1,
      PC_REL = 2'd2
   } pc_sel_e;

   // rel only matters while a jump is requested.
   function automatic pc_sel_e pc_sel(input logic jmp, input logic rel);
      if (!jmp)
         return PC_SEQ;
      else if (rel)
         return PC_REL;
      else
         return PC_ABS;
   endfunction

endpackage

// File: rtl/pc_if.sv
// Fetch-side PC interface.
//   cur  current PC (driven by the PC register)
//   jmp  take a jump this cycle
//   rel  jump mode: 1 = relative (cur+nxt), 0 = absolute (nxt)
//   nxt  absolute target or signed two's-complement offset
// Modports:
//   master  branch/jump resolution logic: drives jmp/rel/nxt, reads cur
//   slave   the PC register itself: drives cur, reads jmp/rel/nxt
interface pc_if #(
   parameter int unsigned XLEN = pc_pkg::XLEN
);
   logic [XLEN-1:0] cur;
   logic            jmp;
   logic            rel;
   logic [XLEN-1:0] nxt;

   modport master (input cur, output jmp, output rel, output nxt);
   modport slave  (output cur, input jmp, input rel, input nxt);
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selection and adders.
//   cur      current PC
//   jmp      jump request
//   rel      relative (1) / absolute (0) jump mode
//   nxt      target or offset
//   next_pc  value the PC register loads on the next edge (when not in reset)
// All additions are XLEN-bit; the carry-out is dropped so wrap-around is silent.
module pc_next
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = pc_pkg::XLEN,
   parameter int unsigned STEP = pc_pkg::ILEN_BYTES
) (
   input  logic [XLEN-1:0] cur,
   input  logic            jmp,
   input  logic            rel,
   input  logic [XLEN-1:0] nxt,
   output logic [XLEN-1:0] next_pc
);

   localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

   pc_sel_e sel;

   assign sel = pc_sel(jmp, rel);

   always_comb begin
      next_pc = cur + STEP_W;
      case (sel)
         PC_ABS:  next_pc = nxt;
         PC_REL:  next_pc = cur + nxt;
         default: next_pc = cur + STEP_W;
      endcase
   end

endmodule

// File: rtl/pc.sv
// Program counter of the MIMA core; cur addresses instruction memory.
//   clk  clock, rising edge
//   rst  synchronous active-low reset (rst=0 loads RESET_VEC on the edge)
//   bus  pc_if slave: cur out, jmp/rel/nxt in
// Reset beats any jump request in the same cycle. Unaligned targets pass
// through untouched; alignment faults are left to the decoder.
module pc
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN      = pc_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VEC = pc_pkg::RESET_VEC,
   parameter int unsigned     STEP      = pc_pkg::ILEN_BYTES
) (
   input  logic clk,
   input  logic rst,
   pc_if.slave  bus
);

   logic [XLEN-1:0] cur_reg;
   logic [XLEN-1:0] cur_next;

   pc_next #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_pc_next (
      .cur     (cur_reg),
      .jmp     (bus.jmp),
      .rel     (bus.rel),
      .nxt     (bus.nxt),
      .next_pc (cur_next)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         cur_reg <= RESET_VEC;
      else
         cur_reg <= cur_next;
   end

   // Straight from the flop: no combinational path from inputs to cur.
   assign bus.cur = cur_reg;

endmodule

// File: tb/tb_pc.sv
// Directed, table-driven bench for pc. Each record holds the inputs applied
// before a rising edge and the cur value required just after that edge.
module tb_pc;
   import pc_pkg::*;

   typedef struct {
      logic        rst;
      logic        jmp;
      logic        rel;
      logic [31:0] nxt;
      logic [31:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vecs[$];

   pc_if #(.XLEN(32)) bus ();

   pc #(
      .XLEN      (32),
      .RESET_VEC (32'h0000_0000),
      .STEP      (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic j, input logic rl,
                               input logic [31:0] n, input logic [31:0] e);
      vec_t v;
      v.rst = r; v.jmp = j; v.rel = rl; v.nxt = n; v.exp = e;
      return v;
   endfunction

   // Drive inputs, take one edge, sample 1 time unit later and compare.
   task automatic step(input string name, input logic r, input logic j,
                       input logic rl, input logic [31:0] n, input logic [31:0] e);
      rst     = r;
      bus.jmp = j;
      bus.rel = rl;
      bus.nxt = n;
      @(posedge clk);
      #1;
      checks++;
      if (bus.cur !== e) begin
         errors++;
         $display("FAIL %s: cur=%h expected=%h (rst=%b jmp=%b rel=%b nxt=%h)",
                  name, bus.cur, e, r, j, rl, n);
      end else begin
         $display("ok   %s: cur=%h (rst=%b jmp=%b rel=%b nxt=%h)",
                  name, bus.cur, r, j, rl, n);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      bus.jmp = 1'b0;
      bus.rel = 1'b0;
      bus.nxt = '0;

      // ------------------------------------------------------------- table
      //                 rst  jmp  rel  nxt            expected cur
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000)); // reset
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_1000)); // abs
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1004));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1008));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_100C));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1010));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1014));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'hFFFF_FFEC, 32'h0000_1000)); // rel -20
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1004));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_1008)); // rel w/o jmp
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_100C)); // nxt ignored
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC)); // abs to top
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000)); // step wrap
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004)); // rel wrap
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_2003, 32'h0000_2003)); // unaligned
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_2007));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_2007)); // rel +0
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000)); // reset wins
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008));

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].jmp, vecs[i].rel,
              vecs[i].nxt, vecs[i].exp);

      // ------------------------------------- held reset with jump traffic
      step("hold_rst_abs", 1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_0000);
      step("hold_rst_rel", 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000);
      step("hold_rst_seq", 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
      step("release_1",    1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);
      step("release_2",    1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008);

      // ------------------------- back-to-back jumps, each one cycle deep
      step("b2b_abs",      1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
      step("b2b_rel_fwd",  1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h8000_0100);
      step("b2b_rel_back", 1'b1, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h8000_0000);
      step("b2b_seq",      1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h8000_0004);

      // ------------------------------------- mid-run reset of a rel jump
      step("mid_rst_rel",  1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000);
      step("mid_rst_after",1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
